// File: rtl/fmt_pkg.sv
// Shared constants, FSM state type and helpers for the radix printer.
package fmt_pkg;

  localparam logic [1:0] RADIX_BIN = 2'b00;
  localparam logic [1:0] RADIX_OCT = 2'b01;
  localparam logic [1:0] RADIX_HEX = 2'b10;

  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_A_LC = 8'h61;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EMIT    = 2'd1,
    ST_NEWLINE = 2'd2
  } state_t;

  // Reserved radix code 11 falls through to hex.
  function automatic int unsigned ndigits(input logic [1:0] radix, input int unsigned width);
    int unsigned bits;
    case (radix)
      RADIX_BIN: bits = 1;
      RADIX_OCT: bits = 3;
      default:   bits = 4;
    endcase
    return (width + bits - 1) / bits;
  endfunction

  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    if (d < 4'd10) return ASCII_0 + {4'b0000, d};
    else           return ASCII_A_LC + {4'b0000, d - 4'd10};
  endfunction

endpackage

// File: rtl/fmt_digit_select.sv
// Combinational extraction of digit[cnt] from a value in the selected radix.
// Bits above DATA_W read as zero, which zero-extends the top digit.
module fmt_digit_select
  import fmt_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic [DATA_W-1:0] value,
  input  logic [1:0]        radix,
  input  logic [CNT_W-1:0]  cnt,
  output logic [3:0]        digit
);

  logic [DATA_W+3:0] ext;
  logic [DATA_W+3:0] shifted;
  logic [CNT_W+1:0]  cnt_x;
  logic [CNT_W+1:0]  sh;
  logic [3:0]        mask;

  assign ext   = {4'b0000, value};
  assign cnt_x = {2'b00, cnt};

  always_comb begin
    sh   = cnt_x << 2;
    mask = 4'hF;
    case (radix)
      RADIX_BIN: begin
        sh   = cnt_x;
        mask = 4'h1;
      end
      RADIX_OCT: begin
        sh   = cnt_x + (cnt_x << 1);
        mask = 4'h7;
      end
      default: begin
        sh   = cnt_x << 2;
        mask = 4'hF;
      end
    endcase
  end

  assign shifted = ext >> sh;
  assign digit   = shifted[3:0] & mask;

endmodule

// File: rtl/fmt_radix_printer.sv
// Serialises one value as fixed-width zero-padded bin/oct/hex ASCII, MSD first,
// with an optional trailing newline. All byte outputs are registered.
module fmt_radix_printer
  import fmt_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_radix,
  input  logic              cmd_newline,
  input  logic [DATA_W-1:0] cmd_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              out_last,
  output logic              busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_t            state, state_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [1:0]        radix_q, radix_d;
  logic              nl_q, nl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_d, last_d;
  logic [7:0]        char_d;
  logic [3:0]        digit_d;

  // Outputs are computed from next-state values so they can be registered
  // and still present the first byte on the cycle after acceptance.
  fmt_digit_select #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_digit (
    .value (val_d),
    .radix (radix_d),
    .cnt   (cnt_d),
    .digit (digit_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      val_q     <= '0;
      radix_q   <= '0;
      nl_q      <= 1'b0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      out_char  <= 8'h00;
      out_last  <= 1'b0;
    end else begin
      state     <= state_d;
      val_q     <= val_d;
      radix_q   <= radix_d;
      nl_q      <= nl_d;
      cnt_q     <= cnt_d;
      out_valid <= valid_d;
      out_char  <= char_d;
      out_last  <= last_d;
    end
  end

  always_comb begin
    state_d = state;
    val_d   = val_q;
    radix_d = radix_q;
    nl_d    = nl_q;
    cnt_d   = cnt_q;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          val_d   = cmd_value;
          radix_d = cmd_radix;
          nl_d    = cmd_newline;
          cnt_d   = CNT_W'(ndigits(cmd_radix, DATA_W) - 1);
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (cnt_q == '0) state_d = nl_q ? ST_NEWLINE : ST_IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      ST_NEWLINE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    char_d  = 8'h00;
    last_d  = 1'b0;
    case (state_d)
      ST_EMIT: begin
        valid_d = 1'b1;
        char_d  = digit_to_ascii(digit_d);
        last_d  = (cnt_d == '0) && !nl_d;
      end
      ST_NEWLINE: begin
        valid_d = 1'b1;
        char_d  = ASCII_LF;
        last_d  = 1'b1;
      end
      default: ;
    endcase
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_fmt_radix_printer.sv
// Directed plus randomized bench for fmt_radix_printer against an arithmetic
// digit-expansion model of the expected byte stream.
module tb_fmt_radix_printer;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_radix;
  logic              cmd_newline;
  logic [DATA_W-1:0] cmd_value;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_char;
  logic              out_last;
  logic              busy;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  fmt_radix_printer #(.DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_radix   (cmd_radix),
    .cmd_newline (cmd_newline),
    .cmd_value   (cmd_value),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_char    (out_char),
    .out_last    (out_last),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected text: repeated division by the base, as many digits as the
  // largest DATA_W-bit value needs, then an optional LF.
  task automatic build_expected(input logic [1:0] r, input logic nl, input logic [DATA_W-1:0] v);
    longint unsigned base, m, x, d;
    int ndig;
    exp_q.delete();
    base = (r == 2'd0) ? 2 : (r == 2'd1) ? 8 : 16;
    m = (64'd1 << DATA_W) - 1;
    ndig = 0;
    while (m > 0) begin
      ndig++;
      m = m / base;
    end
    x = 64'(v);
    for (int i = 0; i < ndig; i++) begin
      d = x % base;
      x = x / base;
      exp_q.push_front((d < 10) ? 8'(48 + d) : 8'(97 + d - 10));
    end
    if (nl) exp_q.push_back(8'h0A);
  endtask

  // mode 0: always ready; 1: ready pattern 1,0,0,...; 2: random ready.
  task automatic run_cmd(input logic [1:0] r, input logic nl, input logic [DATA_W-1:0] v,
                         input int mode, input bit inject);
    int idx, cyc, phase;
    bit injected;
    build_expected(r, nl, v);
    @(negedge clk);
    check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid   = 1'b1;
    cmd_radix   = r;
    cmd_newline = nl;
    cmd_value   = v;
    @(posedge clk);
    #1;
    cmd_valid   = 1'b0;
    cmd_value   = DATA_W'($urandom);
    cmd_radix   = 2'($urandom);
    cmd_newline = 1'($urandom);
    idx = 0; cyc = 0; phase = 0; injected = 1'b0;
    while (idx < exp_q.size() && cyc < 500) begin
      @(negedge clk);
      cyc++;
      check("out_valid", 64'(out_valid), 64'd1);
      check("out_char", 64'(out_char), 64'(exp_q[idx]));
      check("out_last", 64'(out_last), 64'(idx == exp_q.size() - 1));
      check("busy", 64'(busy), 64'd1);
      check("cmd_ready_busy", 64'(cmd_ready), 64'd0);
      if (inject && idx == 2 && !injected) begin
        cmd_valid   = 1'b1;
        cmd_value   = DATA_W'(32'h1234);
        cmd_radix   = 2'd2;
        cmd_newline = 1'b0;
        injected    = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (phase % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      phase++;
      @(posedge clk);
      if (out_ready) idx++;
    end
    if (idx < exp_q.size()) check("stream_timeout", 64'(idx), 64'(exp_q.size()));
    @(negedge clk);
    cmd_valid = 1'b0;
    out_ready = 1'($urandom);
    check("post_cmd_ready", 64'(cmd_ready), 64'd1);
    check("post_out_valid", 64'(out_valid), 64'd0);
    check("post_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_radix = 2'd0; cmd_newline = 1'b0;
    cmd_value = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_char", 64'(out_char), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);

    run_cmd(2'd2, 1'b1, 32'hDEADBEEF, 0, 1'b0);
    run_cmd(2'd0, 1'b0, 32'd5,        0, 1'b0);
    run_cmd(2'd1, 1'b0, 32'hFFFFFFFF, 0, 1'b0);
    run_cmd(2'd2, 1'b0, 32'h0000001F, 1, 1'b0);
    run_cmd(2'd2, 1'b0, 32'hABCD0000, 2, 1'b1);
    run_cmd(2'd2, 1'b0, 32'h00001234, 0, 1'b0);
    run_cmd(2'd3, 1'b1, 32'h0BADF00D, 2, 1'b0);
    run_cmd(2'd1, 1'b1, 32'h00000000, 1, 1'b0);

    // Reset three bytes into a hex command
    @(negedge clk);
    cmd_valid = 1'b1; cmd_radix = 2'd2; cmd_newline = 1'b1; cmd_value = 32'hCAFE0123;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_char", 64'(out_char), 64'h65);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_out_valid", 64'(out_valid), 64'd0);
      check("postrst_cmd_ready", 64'(cmd_ready), 64'd1);
    end

    for (int n = 0; n < 25; n++) begin
      run_cmd(2'($urandom), 1'($urandom), DATA_W'($urandom), $urandom_range(0, 2),
              1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
